// File: rtl/four_req_arbiter.sv
// Four-requester arbiter with fixed-priority or round-robin selection,
// grant hold until done/request drop, and an optional maximum hold time.
module four_req_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rr_mode,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam int unsigned CNT_W = 8;
    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    logic [0:0]       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       last_id_q, last_id_d;

    logic [1:0] fp_win, rr_win, rr_idx, win;

    // Winner selection: highest set bit, or first set bit after last_id.
    always_comb begin
        fp_win = 2'd0;
        rr_win = 2'd0;
        rr_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) fp_win = 2'(i);
        end
        for (int i = 4; i >= 1; i--) begin
            rr_idx = last_id_q + 2'(i);
            if (req[rr_idx]) rr_win = rr_idx;
        end
        win = rr_mode ? rr_win : fp_win;
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_id_d = last_id_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = GRANT;
                    gnt_d     = 4'(4'b0001 << win);
                    gnt_id_d  = win;
                    busy_d    = 1'b1;
                    hold_d    = '0;
                    last_id_d = win;
                end
            end
            GRANT: begin
                if (done || !req[gnt_id_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_id_q <= 2'd3;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_id_q <= last_id_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_four_req_arbiter.sv
// Self-checking bench for four_req_arbiter: directed scenarios then random
// traffic, all compared against a cycle-level behavioural model.
module tb_four_req_arbiter;

    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       rr_mode;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: owner index or -1, cycles the owner has held the grant so far.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 3;
    int m_id    = 0;
    bit m_to    = 1'b0;

    four_req_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rr_mode (rr_mode),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_winner(input logic [3:0] r, input bit rr, input int last);
        int w = -1;
        if (rr) begin
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && r[(last + k) % 4]) w = (last + k) % 4;
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (w < 0 && r[k]) w = k;
            end
        end
        return w;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = 3; m_id = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (req != 4'b0000) begin
                m_owner = pick_winner(req, rr_mode, m_last);
                m_id    = m_owner;
                m_last  = m_owner;
                m_held  = 1;
            end
        end else begin
            m_to = 1'b0;
            if (done || !req[m_owner]) begin
                m_owner = -1;
            end else if (HOLD != 0 && m_held == int'(HOLD)) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end
    endtask

    task automatic step(input logic r_rst, input logic [3:0] r_req, input logic r_rr,
                        input logic r_done);
        logic [3:0] e_gnt;
        rst = r_rst; req = r_req; rr_mode = r_rr; done = r_done;
        @(posedge clk);
        model_edge();
        #1;
        e_gnt = (m_owner >= 0) ? 4'(4'b0001 << m_owner) : 4'b0000;
        chk("gnt", 8'(gnt), 8'(e_gnt));
        chk("gnt_id", 8'(gnt_id), 8'(m_id));
        chk("busy", 8'(busy), 8'(m_owner >= 0));
        chk("timeout", 8'(timeout), 8'(m_to));
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; rr_mode = 1'b0; done = 1'b0;

        // Reset state
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        chk("rst_gnt", 8'(gnt), 8'h00);
        chk("rst_id", 8'(gnt_id), 8'h00);

        // Fixed priority with all requesting: always 3, dead cycle between grants
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b1111, 0, 0);
            chk("fp_gnt", 8'(gnt), 8'h08);
            step(0, 4'b1111, 0, 1);
            chk("fp_dead", 8'(gnt), 8'h00);
            chk("fp_id", 8'(gnt_id), 8'h03);
        end

        // Round robin from reset: 0,1,2,3,0
        step(1, 4'b0000, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b1111, 1, 0);
            chk("rr_id", 8'(gnt_id), 8'(i % 4));
            step(0, 4'b1111, 1, 1);
        end

        // Hold limit: exactly HOLD cycles of grant, then timeout in dead cycle
        step(1, 4'b0000, 0, 0);
        for (int i = 0; i < int'(HOLD); i++) begin
            step(0, 4'b0100, 0, 0);
            chk("hold_gnt", 8'(gnt), 8'h04);
        end
        step(0, 4'b0100, 0, 0);
        chk("hold_to", 8'(timeout), 8'h01);
        chk("hold_dead", 8'(gnt), 8'h00);
        step(0, 4'b0100, 0, 0);
        chk("hold_regrant", 8'(gnt), 8'h04);
        chk("hold_to_clr", 8'(timeout), 8'h00);
        step(0, 4'b0100, 0, 1);

        // Request drop: owner 1 drops, requester 0 wins after dead cycle
        for (int i = 0; i < 3; i++) step(0, 4'b0010, 0, 0);
        step(0, 4'b0001, 0, 0);
        chk("drop_dead", 8'(gnt), 8'h00);
        step(0, 4'b0001, 0, 0);
        chk("drop_gnt", 8'(gnt), 8'h01);
        chk("drop_id", 8'(gnt_id), 8'h00);
        chk("drop_to", 8'(timeout), 8'h00);
        step(0, 4'b0000, 0, 0);

        // done coincident with hold limit: normal release, no timeout
        for (int i = 0; i < int'(HOLD); i++) step(0, 4'b0100, 0, 0);
        step(0, 4'b0100, 0, 1);
        chk("done_hold_to", 8'(timeout), 8'h00);

        // done while idle changes nothing
        step(0, 4'b0000, 0, 1);
        step(0, 4'b0000, 0, 1);
        chk("idle_done_gnt", 8'(gnt), 8'h00);
        chk("idle_done_id", 8'(gnt_id), 8'h02);

        // Reset mid-grant, then round robin restarts from index 0
        step(0, 4'b1000, 1, 0);
        step(0, 4'b1000, 1, 0);
        step(1, 4'b1000, 1, 0);
        chk("rstmid_gnt", 8'(gnt), 8'h00);
        chk("rstmid_id", 8'(gnt_id), 8'h00);
        step(0, 4'b1010, 1, 0);
        chk("rstmid_rr", 8'(gnt_id), 8'h01);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
